// File: rtl/out_channel_checker.sv
// Streaming checker for the program executor's out channel.
// Accepted words are buffered in a small FIFO and compared in order against a
// loadable expected table. Wrong, extra and missing words are all reported via
// mismatch_index; finished/success summarise the run.
module out_channel_checker #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned NOUT  = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exp_we,
    input  logic [AW-1:0]    exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             start,
    input  logic             out_valid,
    input  logic [WIDTH-1:0] out_data,
    output logic             out_ready,
    input  logic             prog_done,
    input  logic             hold,
    output logic             finished,
    output logic             success,
    output logic [AW:0]      mismatch_index,
    output logic [AW:0]      received_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW:0]   AllOnes = '1;
    localparam logic [AW:0]   NoutC   = (AW + 1)'(NOUT);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} stateType;

    stateType         state;
    logic [WIDTH-1:0] expTable [2**AW];
    logic [WIDTH-1:0] fifoMem  [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    fifoCount;
    logic [AW:0]      idx;
    logic             doneSeen;
    logic             failed;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] popWord;
    logic             popBad;
    logic             missing;
    logic [AW:0]      finalMismatch;
    logic             goDone;

    // Handshake, pop and end-of-run decisions, all derived from registered state.
    always_comb begin
        out_ready     = (state == StRun) && (fifoCount < DepthC);
        push          = out_ready && out_valid;
        pop           = (state == StRun) && (fifoCount != '0) && !hold;
        popWord       = fifoMem[rdPtr];
        // Past the end of the table every popped word is an extra output.
        popBad        = (idx >= NoutC) || (popWord != expTable[idx[AW-1:0]]);
        missing       = (idx < NoutC) && !failed;
        finalMismatch = missing ? idx : mismatch_index;
        goDone        = (state == StRun) && doneSeen && (fifoCount == '0) && !push;
    end

    // Expected table: writable only while idle, never cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && (state == StIdle) && exp_we && ({1'b0, exp_addr} < NoutC)) begin
            expTable[exp_addr] <= exp_data;
        end
    end

    // FIFO storage; pointers and count live in the control block below.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= out_data;
        end
    end

    // Run control: FSM, FIFO pointers, comparison bookkeeping and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= StIdle;
            wrPtr          <= '0;
            rdPtr          <= '0;
            fifoCount      <= '0;
            idx            <= '0;
            doneSeen       <= 1'b0;
            failed         <= 1'b0;
            finished       <= 1'b0;
            success        <= 1'b0;
            mismatch_index <= AllOnes;
            received_count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (push) begin
                        wrPtr <= wrPtr + 1'b1;
                        if (received_count != AllOnes) begin
                            received_count <= received_count + 1'b1;
                        end
                    end
                    if (pop) begin
                        rdPtr <= rdPtr + 1'b1;
                        if (idx != AllOnes) begin
                            idx <= idx + 1'b1;
                        end
                        if (popBad && !failed) begin
                            failed         <= 1'b1;
                            mismatch_index <= idx;
                        end
                    end
                    // A simultaneous push and pop leaves the occupancy unchanged.
                    if (push && !pop) begin
                        fifoCount <= fifoCount + 1'b1;
                    end else if (pop && !push) begin
                        fifoCount <= fifoCount - 1'b1;
                    end
                    if (prog_done) begin
                        doneSeen <= 1'b1;
                    end
                    // goDone implies an empty FIFO, so no pop competes with this update.
                    if (goDone) begin
                        state          <= StDone;
                        finished       <= 1'b1;
                        mismatch_index <= finalMismatch;
                        success        <= (finalMismatch == AllOnes);
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_channel_checker.sv
// Self-checking bench for out_channel_checker: directed scenarios followed by
// randomised runs scored against a queue-based reference model.
module tb_out_channel_checker;

    localparam int WIDTH = 12;
    localparam int NOUT  = 3;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int NONE  = 31;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             exp_we = 1'b0;
    logic [AW-1:0]    exp_addr = '0;
    logic [WIDTH-1:0] exp_data = '0;
    logic             start = 1'b0;
    logic             out_valid = 1'b0;
    logic [WIDTH-1:0] out_data = '0;
    logic             out_ready;
    logic             prog_done = 1'b0;
    logic             hold = 1'b0;
    logic             finished;
    logic             success;
    logic [AW:0]      mismatch_index;
    logic [AW:0]      received_count;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] tbl [NOUT];
    logic [WIDTH-1:0] acc [$];

    out_channel_checker #(
        .WIDTH (WIDTH),
        .NOUT  (NOUT),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .exp_we         (exp_we),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .start          (start),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .prog_done      (prog_done),
        .hold           (hold),
        .finished       (finished),
        .success        (success),
        .mismatch_index (mismatch_index),
        .received_count (received_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // First failing index from the rules: wrong word, extra word, then missing word.
    function automatic int expMismatch();
        for (int i = 0; i < acc.size(); i++) begin
            if (i >= NOUT) return i;
            if (acc[i] != tbl[i]) return i;
        end
        if (acc.size() < NOUT) return acc.size();
        return NONE;
    endfunction

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        out_valid = 1'b0;
        hold = 1'b0;
        prog_done = 1'b0;
        start = 1'b0;
        exp_we = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        acc.delete();
    endtask

    task automatic loadTable(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] vals [NOUT];
        vals[0] = a;
        vals[1] = b;
        vals[2] = c;
        for (int i = 0; i < NOUT; i++) begin
            @(negedge clock);
            exp_we = 1'b1;
            exp_addr = AW'(i);
            exp_data = vals[i];
            tbl[i] = vals[i];
        end
        // Out-of-range address must be ignored.
        @(negedge clock);
        exp_addr = AW'(NOUT);
        exp_data = 12'hfff;
        @(negedge clock);
        exp_we = 1'b0;
    endtask

    task automatic doStart();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the word was accepted.
    task automatic pushWord(input logic [WIDTH-1:0] w);
        int n = 0;
        out_valid = 1'b1;
        out_data = w;
        while (!out_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            check("push_timeout_ready", 32'(out_ready), 1);
        end else begin
            @(posedge clock);
            acc.push_back(w);
            @(negedge clock);
        end
        out_valid = 1'b0;
    endtask

    task automatic finishRun(input string tag);
        int n = 0;
        int em;
        hold = 1'b0;
        prog_done = 1'b1;
        @(negedge clock);
        prog_done = 1'b0;
        while (!finished && n < 40) begin
            @(negedge clock);
            n++;
        end
        em = expMismatch();
        check({tag, "_finished"}, 32'(finished), 1);
        check({tag, "_success"}, 32'(success), (em == NONE) ? 1 : 0);
        check({tag, "_mismatch"}, 32'(mismatch_index), em);
        check({tag, "_received"}, 32'(received_count), (acc.size() > NONE) ? NONE : acc.size());
        check({tag, "_ready_done"}, 32'(out_ready), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int nw;

        doReset();
        check("rst_finished", 32'(finished), 0);
        check("rst_success", 32'(success), 0);
        check("rst_mismatch", 32'(mismatch_index), NONE);
        check("rst_received", 32'(received_count), 0);
        check("rst_ready", 32'(out_ready), 0);

        // All three words correct, with exact finish latency.
        loadTable(12'd11, 12'd22, 12'd33);
        check("idle_ready", 32'(out_ready), 0);
        doStart();
        check("run_ready", 32'(out_ready), 1);
        pushWord(12'd11);
        pushWord(12'd22);
        pushWord(12'd33);
        repeat (3) @(negedge clock);
        check("pass_no_finish_before_done", 32'(finished), 0);
        prog_done = 1'b1;
        @(negedge clock);
        prog_done = 1'b0;
        check("pass_latency_early", 32'(finished), 0);
        @(negedge clock);
        check("pass_latency", 32'(finished), 1);
        finishRun("pass");
        doStart();
        check("done_ignores_start", 32'(finished), 1);

        // Wrong last word.
        doReset();
        loadTable(12'd11, 12'd22, 12'd33);
        doStart();
        pushWord(12'd11);
        pushWord(12'd22);
        pushWord(12'd34);
        finishRun("wrong");

        // Missing word.
        doReset();
        loadTable(12'd11, 12'd22, 12'd33);
        doStart();
        pushWord(12'd11);
        pushWord(12'd22);
        finishRun("missing");

        // Extra word.
        doReset();
        doStart();
        pushWord(12'd11);
        pushWord(12'd22);
        pushWord(12'd33);
        pushWord(12'd44);
        finishRun("extra");

        // Backpressure: fill FIFO under hold, fifth word must stall.
        doReset();
        doStart();
        hold = 1'b1;
        pushWord(12'd11);
        pushWord(12'd22);
        pushWord(12'd33);
        pushWord(12'd44);
        check("full_ready", 32'(out_ready), 0);
        out_valid = 1'b1;
        out_data = 12'd55;
        repeat (2) @(negedge clock);
        check("full_stall_ready", 32'(out_ready), 0);
        check("full_stall_count", 32'(received_count), 4);
        hold = 1'b0;
        pushWord(12'd55);
        finishRun("hold");

        // Reset mid-run, then rerun with the retained table; exp_we during RUN ignored.
        doReset();
        doStart();
        hold = 1'b1;
        pushWord(12'd11);
        pushWord(12'd22);
        doReset();
        check("midrst_ready", 32'(out_ready), 0);
        check("midrst_received", 32'(received_count), 0);
        check("midrst_finished", 32'(finished), 0);
        doStart();
        exp_we = 1'b1;
        exp_addr = '0;
        exp_data = 12'd99;
        @(negedge clock);
        exp_we = 1'b0;
        pushWord(12'd11);
        pushWord(12'd22);
        pushWord(12'd33);
        finishRun("midrst");

        // Randomised runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            doReset();
            loadTable(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            doStart();
            nw = $urandom_range(0, 6);
            for (int i = 0; i < nw; i++) begin
                // Hold only while the FIFO cannot yet be full, so pushes never deadlock.
                hold = (i < DEPTH) ? (($urandom % 3) == 0) : 1'b0;
                if (i < NOUT && ($urandom % 4) != 0) w = tbl[i];
                else w = WIDTH'($urandom);
                pushWord(w);
                if (($urandom % 2) == 0) @(negedge clock);
            end
            finishRun($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
